// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit / 12-bit-PC five-stage CPU.
// Field positions, widths and the hazard controller FSM encoding.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 12;
    localparam int REG_W  = 4;

    localparam logic [INST_W-1:0] NOP = 16'h0000;

    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch flushes and memory
// wait stalls; outputs are combinational from FSM state plus inputs.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] instD,
    input  logic              useRsD,
    input  logic              useRtD,
    input  logic [REG_W-1:0]  rdE,
    input  logic              memReadE,
    input  logic              branchTakenE,
    input  logic              memReqM,
    input  logic              memReadyM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              busy,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    state_t     state, state_n;
    logic [1:0] lcnt, lcnt_n;

    logic [REG_W-1:0] rs, rt;
    logic             load_use, mem_wait;
    logic             unused_inst;

    logic sf_c, sd_c, se_c, sm_c, fd_c, fe_c;

    assign rs          = instD[RS_HI:RS_LO];
    assign rt          = instD[RT_HI:RT_LO];
    assign unused_inst = ^instD[INST_W-1:RS_HI+1];

    // r0 is hardwired zero, so a load targeting it can never create a hazard
    assign load_use = memReadE && (rdE != '0) &&
                      ((useRsD && (rs == rdE)) || (useRtD && (rt == rdE)));
    assign mem_wait = memReqM && !memReadyM;

    always_comb begin
        state_n = state;
        lcnt_n  = lcnt;
        sf_c    = 1'b0;
        sd_c    = 1'b0;
        se_c    = 1'b0;
        sm_c    = 1'b0;
        fd_c    = 1'b0;
        fe_c    = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    sf_c    = 1'b1;
                    sd_c    = 1'b1;
                    se_c    = 1'b1;
                    sm_c    = 1'b1;
                    state_n = ST_MEMWAIT;
                end else if (branchTakenE) begin
                    // the dependent instruction is flushed, so any load-use is moot
                    fd_c = 1'b1;
                    fe_c = 1'b1;
                end else if (load_use) begin
                    sf_c   = 1'b1;
                    sd_c   = 1'b1;
                    fe_c   = 1'b1;
                    lcnt_n = LAT_M1;
                    if (LOAD_LAT > 1) begin
                        state_n = ST_LDUSE;
                    end
                end
            end
            ST_LDUSE: begin
                sf_c = 1'b1;
                sd_c = 1'b1;
                if (mem_wait) begin
                    // freeze the bubble count; holding D/E overrides the bubble insert
                    se_c = 1'b1;
                    sm_c = 1'b1;
                end else begin
                    fe_c = 1'b1;
                    if (lcnt == 2'd1) begin
                        lcnt_n  = 2'd0;
                        state_n = ST_RUN;
                    end else begin
                        lcnt_n = lcnt - 2'd1;
                    end
                end
            end
            ST_MEMWAIT: begin
                if (mem_wait) begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    se_c = 1'b1;
                    sm_c = 1'b1;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
                lcnt_n  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            lcnt  <= 2'd0;
        end else begin
            state <= state_n;
            lcnt  <= lcnt_n;
        end
    end

    // reset gates the outputs asynchronously so nothing leaks while reset is low
    assign stallF = sf_c && reset;
    assign stallD = sd_c && reset;
    assign stallE = se_c && reset;
    assign stallM = sm_c && reset;
    assign flushD = fd_c && reset;
    assign flushE = fe_c && reset;
    assign busy   = (state != ST_RUN) && reset;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallF),
        .cnt   (stallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushD),
        .cnt   (flushCnt)
    );

endmodule
